cursor_ctrl: RTL and testbench

Key-command consumer sitting directly downstream of the PS/2 keyboard decoder. Takes the decoder's 3-bit simplified key code and its one-cycle valid pulse, and maintains a cursor position on a ROWS×COLS game board. Runs a select/cancel state machine and issues adjacent-cell swap requests to the game logic over a valid/ready handshake.

---
 rtl/cursor_ctrl_if.sv | 25 ++
 rtl/cursor_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_cursor_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/cursor_ctrl_if.sv
// cursor_ctrl_if: swap request channel to the game logic.
// Master raises swap_valid with the target cell; slave accepts with swap_ready.
interface cursor_ctrl_if #(
  parameter int ROW_W = 3,
  parameter int COL_W = 3
);
  logic             swap_valid;
  logic             swap_ready;
  logic [ROW_W-1:0] swap_r1;
  logic [COL_W-1:0] swap_c1;

  modport master (
    output swap_valid,
    output swap_r1,
    output swap_c1,
    input  swap_ready
  );

  modport slave (
    input  swap_valid,
    input  swap_r1,
    input  swap_c1,
    output swap_ready
  );
endinterface

// File: rtl/cursor_ctrl.sv
// cursor_ctrl: cursor/select FSM issuing adjacent-cell swap requests.
// Optional macro CURSOR_WRAP_EN: IDLE arrow moves wrap instead of clamping.
module cursor_ctrl #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int ROW_W = 3,
  parameter int COL_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       key_code,
  input  logic             key_valid,
  output logic [ROW_W-1:0] cur_row,
  output logic [COL_W-1:0] cur_col,
  output logic             sel_active,
  output logic [ROW_W-1:0] sel_row,
  output logic [COL_W-1:0] sel_col,
  output logic             key_dropped,
  cursor_ctrl_if.master    swp
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEL,
    S_REQ
  } state_t;

  localparam logic [2:0] K_UP  = 3'd0;
  localparam logic [2:0] K_DN  = 3'd1;
  localparam logic [2:0] K_LT  = 3'd2;
  localparam logic [2:0] K_RT  = 3'd3;
  localparam logic [2:0] K_SEL = 3'd4;
  localparam logic [2:0] K_CAN = 3'd5;

  localparam logic [ROW_W-1:0] RMAX = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] CMAX = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] R1   = ROW_W'(1);
  localparam logic [COL_W-1:0] C1   = COL_W'(1);

`ifdef CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  state_t           r_state;
  state_t           w_state;
  logic [ROW_W-1:0] r_cur_row, w_cur_row;
  logic [COL_W-1:0] r_cur_col, w_cur_col;
  logic             r_sel_act, w_sel_act;
  logic [ROW_W-1:0] r_sel_row, w_sel_row;
  logic [COL_W-1:0] r_sel_col, w_sel_col;
  logic             r_swp_vld, w_swp_vld;
  logic [ROW_W-1:0] r_swp_r1, w_swp_r1;
  logic [COL_W-1:0] r_swp_c1, w_swp_c1;
  logic             r_kdrop, w_kdrop;

  logic             w_arrow;
  logic             w_selk;
  logic             w_cank;
  logic [ROW_W-1:0] w_mv_row;
  logic [COL_W-1:0] w_mv_col;
  logic [ROW_W-1:0] w_tg_row;
  logic [COL_W-1:0] w_tg_col;
  logic             w_tg_ok;

  assign w_arrow = key_valid & ~key_code[2];
  assign w_selk  = key_valid & (key_code == K_SEL);
  assign w_cank  = key_valid & (key_code == K_CAN);

  // Cursor move for IDLE: clamp at edges, or wrap when enabled
  always_comb begin
    w_mv_row = r_cur_row;
    w_mv_col = r_cur_col;
    case (key_code)
      K_UP:
        if (r_cur_row != '0) w_mv_row = r_cur_row - R1;
        else if (WRAP)       w_mv_row = RMAX;
      K_DN:
        if (r_cur_row != RMAX) w_mv_row = r_cur_row + R1;
        else if (WRAP)         w_mv_row = '0;
      K_LT:
        if (r_cur_col != '0) w_mv_col = r_cur_col - C1;
        else if (WRAP)       w_mv_col = CMAX;
      K_RT:
        if (r_cur_col != CMAX) w_mv_col = r_cur_col + C1;
        else if (WRAP)         w_mv_col = '0;
      default: ;
    endcase
  end

  // Swap target from the selected cell; never wraps
  always_comb begin
    w_tg_row = r_sel_row;
    w_tg_col = r_sel_col;
    w_tg_ok  = 1'b0;
    case (key_code)
      K_UP: begin
        w_tg_ok  = (r_sel_row != '0);
        w_tg_row = r_sel_row - R1;
      end
      K_DN: begin
        w_tg_ok  = (r_sel_row != RMAX);
        w_tg_row = r_sel_row + R1;
      end
      K_LT: begin
        w_tg_ok  = (r_sel_col != '0);
        w_tg_col = r_sel_col - C1;
      end
      K_RT: begin
        w_tg_ok  = (r_sel_col != CMAX);
        w_tg_col = r_sel_col + C1;
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state;
  end

  // Next-state decode
  always_comb begin
    w_state = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_selk) w_state = S_SEL;
      S_SEL:
        if (w_selk || w_cank)      w_state = S_IDLE;
        else if (w_arrow && w_tg_ok) w_state = S_REQ;
      S_REQ:
        if (swp.swap_ready) w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  // Output next values; all outputs are registered below
  always_comb begin
    w_cur_row = r_cur_row;
    w_cur_col = r_cur_col;
    w_sel_act = r_sel_act;
    w_sel_row = r_sel_row;
    w_sel_col = r_sel_col;
    w_swp_vld = r_swp_vld;
    w_swp_r1  = r_swp_r1;
    w_swp_c1  = r_swp_c1;
    w_kdrop   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_arrow) begin
          w_cur_row = w_mv_row;
          w_cur_col = w_mv_col;
        end
        if (w_selk) begin
          w_sel_act = 1'b1;
          w_sel_row = r_cur_row;
          w_sel_col = r_cur_col;
        end
      end
      S_SEL: begin
        if (w_selk || w_cank) begin
          w_sel_act = 1'b0;
        end else if (w_arrow && w_tg_ok) begin
          w_swp_vld = 1'b1;
          w_swp_r1  = w_tg_row;
          w_swp_c1  = w_tg_col;
        end
      end
      S_REQ: begin
        w_kdrop = key_valid;
        if (swp.swap_ready) begin
          w_cur_row = r_swp_r1;
          w_cur_col = r_swp_c1;
          w_sel_act = 1'b0;
          w_swp_vld = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Output/data registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cur_row <= '0;
      r_cur_col <= '0;
      r_sel_act <= 1'b0;
      r_sel_row <= '0;
      r_sel_col <= '0;
      r_swp_vld <= 1'b0;
      r_swp_r1  <= '0;
      r_swp_c1  <= '0;
      r_kdrop   <= 1'b0;
    end else begin
      r_cur_row <= w_cur_row;
      r_cur_col <= w_cur_col;
      r_sel_act <= w_sel_act;
      r_sel_row <= w_sel_row;
      r_sel_col <= w_sel_col;
      r_swp_vld <= w_swp_vld;
      r_swp_r1  <= w_swp_r1;
      r_swp_c1  <= w_swp_c1;
      r_kdrop   <= w_kdrop;
    end
  end

  assign cur_row        = r_cur_row;
  assign cur_col        = r_cur_col;
  assign sel_active     = r_sel_act;
  assign sel_row        = r_sel_row;
  assign sel_col        = r_sel_col;
  assign key_dropped    = r_kdrop;
  assign swp.swap_valid = r_swp_vld;
  assign swp.swap_r1    = r_swp_r1;
  assign swp.swap_c1    = r_swp_c1;

endmodule

// File: tb/tb_cursor_ctrl.sv
// tb_cursor_ctrl: directed vectors for cursor_ctrl (ROWS=COLS=8).
// Expected values are hand-computed; wrap build selected by CURSOR_WRAP_EN.
module tb_cursor_ctrl;

  localparam logic [2:0] K_UP  = 3'd0;
  localparam logic [2:0] K_DN  = 3'd1;
  localparam logic [2:0] K_LT  = 3'd2;
  localparam logic [2:0] K_RT  = 3'd3;
  localparam logic [2:0] K_SEL = 3'd4;
  localparam logic [2:0] K_CAN = 3'd5;

`ifdef CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] key_code;
  logic       key_valid;
  logic [2:0] cur_row;
  logic [2:0] cur_col;
  logic       sel_active;
  logic [2:0] sel_row;
  logic [2:0] sel_col;
  logic       key_dropped;

  int n_vec = 0;
  int n_err = 0;

  cursor_ctrl_if #(.ROW_W(3), .COL_W(3)) bus ();

  cursor_ctrl #(
    .ROWS(8), .COLS(8), .ROW_W(3), .COL_W(3)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .cur_row     (cur_row),
    .cur_col     (cur_col),
    .sel_active  (sel_active),
    .sel_row     (sel_row),
    .sel_col     (sel_col),
    .key_dropped (key_dropped),
    .swp         (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic chk_pos(input string tag, input int r, input int c);
    chk({tag, "_row"}, int'(cur_row), r);
    chk({tag, "_col"}, int'(cur_col), c);
  endtask

  task automatic chk_rst(input string tag);
    chk_pos(tag, 0, 0);
    chk({tag, "_sa"}, int'(sel_active), 0);
    chk({tag, "_sr"}, int'(sel_row), 0);
    chk({tag, "_sc"}, int'(sel_col), 0);
    chk({tag, "_sv"}, int'(bus.swap_valid), 0);
    chk({tag, "_r1"}, int'(bus.swap_r1), 0);
    chk({tag, "_c1"}, int'(bus.swap_c1), 0);
    chk({tag, "_kd"}, int'(key_dropped), 0);
  endtask

  // Entered and left on a falling edge
  task automatic press(input logic [2:0] c);
    key_code  = c;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    key_code = 3'd0;
    key_valid = 1'b0;
    bus.swap_ready = 1'b0;
    #1 chk_rst("rst0");

    // ready with no request pending is ignored
    @(negedge clk);
    rst_n = 1'b1;
    bus.swap_ready = 1'b1;
    @(negedge clk);
    bus.swap_ready = 1'b0;
    chk("idle_rdy_sv", int'(bus.swap_valid), 0);
    chk_pos("idle_rdy", 0, 0);

    // moves, one-cycle latency each
    press(K_RT); chk_pos("rt1", 0, 1);
    press(K_RT); chk_pos("rt2", 0, 2);
    press(K_RT); chk_pos("rt3", 0, 3);
    press(K_DN); chk_pos("dn1", 1, 3);
    press(K_DN); chk_pos("dn2", 2, 3);
    press(3'd6); chk_pos("rsv", 2, 3);
    press(K_CAN); chk_pos("can_idle", 2, 3);

    // top/left edges
    do_reset();
    press(K_UP);
    chk_pos("edge_up", WRAP ? 7 : 0, 0);
    press(K_LT);
    chk_pos("edge_lt", WRAP ? 7 : 0, WRAP ? 7 : 0);

    // right edge
    do_reset();
    repeat (7) press(K_RT);
    chk_pos("rt7", 0, 7);
    press(K_RT);
    chk_pos("edge_rt", 0, WRAP ? 0 : 7);

    // select at (2,3), swap right, ready delayed
    do_reset();
    press(K_DN); press(K_DN);
    press(K_RT); press(K_RT); press(K_RT);
    press(K_SEL);
    chk("sel_sa", int'(sel_active), 1);
    chk("sel_sr", int'(sel_row), 2);
    chk("sel_sc", int'(sel_col), 3);
    chk("sel_sv", int'(bus.swap_valid), 0);
    press(K_RT);
    for (int i = 0; i < 5; i++) begin
      chk("req_sv", int'(bus.swap_valid), 1);
      chk("req_r1", int'(bus.swap_r1), 2);
      chk("req_c1", int'(bus.swap_c1), 4);
      chk("req_sc", int'(sel_col), 3);
      @(negedge clk);
    end
    bus.swap_ready = 1'b1;
    chk("req_sv6", int'(bus.swap_valid), 1);
    @(negedge clk);
    bus.swap_ready = 1'b0;
    chk("hs_sv", int'(bus.swap_valid), 0);
    chk("hs_sa", int'(sel_active), 0);
    chk_pos("hs", 2, 4);
    press(K_LT);
    chk_pos("post_hs", 2, 3);

    // select at (0,5), up is off board
    do_reset();
    repeat (5) press(K_RT);
    press(K_SEL);
    press(K_UP);
    chk("off_sv", int'(bus.swap_valid), 0);
    chk("off_sa", int'(sel_active), 1);
    press(K_CAN);
    chk("can_sa", int'(sel_active), 0);
    chk_pos("can", 0, 5);
    press(K_SEL);
    chk("sel2_sa", int'(sel_active), 1);
    press(K_SEL);
    chk("desel_sa", int'(sel_active), 0);

    // keys during request are dropped
    press(K_SEL);
    press(K_DN);
    chk("dq_sv", int'(bus.swap_valid), 1);
    chk("dq_r1", int'(bus.swap_r1), 1);
    chk("dq_c1", int'(bus.swap_c1), 5);
    key_valid = 1'b1;
    key_code = K_CAN;
    @(negedge clk);
    chk("drop1", int'(key_dropped), 1);
    key_code = K_LT;
    @(negedge clk);
    chk("drop2", int'(key_dropped), 1);
    key_code = K_SEL;
    @(negedge clk);
    chk("drop3", int'(key_dropped), 1);
    key_valid = 1'b0;
    @(negedge clk);
    chk("drop_end", int'(key_dropped), 0);
    chk("dq_sv2", int'(bus.swap_valid), 1);
    chk("dq_r1b", int'(bus.swap_r1), 1);
    chk("dq_c1b", int'(bus.swap_c1), 5);
    chk("dq_sa", int'(sel_active), 1);
    // key on the handshake cycle is also dropped
    key_valid = 1'b1;
    key_code = K_RT;
    bus.swap_ready = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    bus.swap_ready = 1'b0;
    chk("hsdrop_kd", int'(key_dropped), 1);
    chk("hsdrop_sv", int'(bus.swap_valid), 0);
    chk("hsdrop_sa", int'(sel_active), 0);
    chk_pos("hsdrop", 1, 5);
    @(negedge clk);
    chk("hsdrop_kd0", int'(key_dropped), 0);

    // reset in the middle of a request
    press(K_SEL);
    press(K_RT);
    chk("mr_sv", int'(bus.swap_valid), 1);
    #2 rst_n = 1'b0;
    #1 chk_rst("mr");
    @(negedge clk);
    rst_n = 1'b1;
    bus.swap_ready = 1'b1;
    @(negedge clk);
    bus.swap_ready = 1'b0;
    chk("mr_rdy_sv", int'(bus.swap_valid), 0);
    chk_pos("mr_rdy", 0, 0);
    press(K_RT);
    chk_pos("mr_mv", 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
